// File: rtl/fifo_wr_arbiter_if.sv
// Write-port bundle between the requesters, fifo_wr_arbiter and the async FIFO write side.
// The arbiter connects through master; the requester/FIFO side connects through slave.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8
);
  localparam int IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       ack;
  logic                     fifo_wfull;
  logic                     fifo_winc;
  logic [WIDTH-1:0]         fifo_wdata;
  logic [IDW-1:0]           grant_id;

  modport master (
    input  req, req_data, fifo_wfull,
    output ack, fifo_winc, fifo_wdata, grant_id
  );

  modport slave (
    output req, req_data, fifo_wfull,
    input  ack, fifo_winc, fifo_wdata, grant_id
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-locked arbiter sharing one async-FIFO write port; single registered output stage.
// Optional macro FIFO_WR_ARB_PRIO0_EN makes requester 0 strict high priority.
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 8,
  parameter int BURST_LEN = 4
) (
  input logic                clk,
  input logic                rst,
  fifo_wr_arbiter_if.master  bus
);
  localparam int IDW  = $clog2(NUM_REQ);
  localparam int CNTW = $clog2(BURST_LEN + 1);

  typedef enum logic {IDLE, OWN} state_t;

  state_t            state_q, state_d;
  logic [IDW-1:0]    owner_q, owner_d;
  logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [CNTW-1:0]   burst_cnt_q, burst_cnt_d;
  logic [IDW-1:0]    grant_id_q, grant_id_d;
  logic              winc_q, winc_d;
  logic [WIDTH-1:0]  wdata_q, wdata_d;

  logic              load_en;
  logic              sel_hit;
  logic [IDW-1:0]    sel_idx;
  logic              release_own;
  logic              prio_kick;
  logic              grant;
  logic [IDW-1:0]    grant_idx;
  logic [NUM_REQ-1:0] ack_vec;
  int unsigned       scan_idx;

  // The stage can take a word when empty or when its word leaves this edge.
  assign load_en = !winc_q || !bus.fifo_wfull;

  // IDLE selection: first request at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    sel_hit  = 1'b0;
    sel_idx  = '0;
    scan_idx = 0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      scan_idx = 32'(rr_ptr_q) + j;
      if (scan_idx >= 32'(NUM_REQ)) scan_idx = scan_idx - 32'(NUM_REQ);
      if (!sel_hit && bus.req[scan_idx]) begin
        sel_hit = 1'b1;
        sel_idx = IDW'(scan_idx);
      end
    end
`ifdef FIFO_WR_ARB_PRIO0_EN
    if (bus.req[0]) begin
      sel_hit = 1'b1;
      sel_idx = '0;
    end
`endif
  end

  always_comb begin
`ifdef FIFO_WR_ARB_PRIO0_EN
    prio_kick = (owner_q != '0) && bus.req[0];
`else
    prio_kick = 1'b0;
`endif
    release_own = !bus.req[owner_q] || (burst_cnt_q >= CNTW'(BURST_LEN)) || prio_kick;
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    grant_id_d  = grant_id_q;
    winc_d      = winc_q;
    wdata_d     = wdata_q;
    grant       = 1'b0;
    grant_idx   = owner_q;
    ack_vec     = '0;

    // Everything freezes while the stage holds a word the FIFO refuses.
    if (load_en) begin
      unique case (state_q)
        IDLE: begin
          if (sel_hit) begin
            grant       = 1'b1;
            grant_idx   = sel_idx;
            state_d     = OWN;
            owner_d     = sel_idx;
            grant_id_d  = sel_idx;
            burst_cnt_d = CNTW'(1);
          end
        end
        OWN: begin
          if (release_own) begin
            state_d     = IDLE;
            burst_cnt_d = '0;
`ifdef FIFO_WR_ARB_PRIO0_EN
            if (owner_q != '0)
              rr_ptr_d = (owner_q == IDW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
`else
            rr_ptr_d = (owner_q == IDW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
`endif
          end else begin
            grant       = 1'b1;
            burst_cnt_d = burst_cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase

      winc_d = grant;
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
        if (grant && (32'(grant_idx) == j)) begin
          wdata_d    = bus.req_data[j*WIDTH +: WIDTH];
          ack_vec[j] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
      grant_id_q  <= '0;
      winc_q      <= 1'b0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
      grant_id_q  <= grant_id_d;
      winc_q      <= winc_d;
      wdata_q     <= wdata_d;
    end
  end

  assign bus.ack        = rst ? '0 : ack_vec;
  assign bus.fifo_winc  = winc_q;
  assign bus.fifo_wdata = wdata_q;
  assign bus.grant_id   = grant_id_q;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: three instances (BURST_LEN 4/2/1) with per-instance
// expected-word queues popped whenever a word leaves the output stage.
module tb_fifo_wr_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.NUM_REQ(4), .WIDTH(8)) ia ();
  fifo_wr_arbiter_if #(.NUM_REQ(4), .WIDTH(8)) ib ();
  fifo_wr_arbiter_if #(.NUM_REQ(3), .WIDTH(8)) ic ();

  fifo_wr_arbiter #(.NUM_REQ(4), .WIDTH(8), .BURST_LEN(4)) dut_a (.clk(clk), .rst(rst), .bus(ia));
  fifo_wr_arbiter #(.NUM_REQ(4), .WIDTH(8), .BURST_LEN(2)) dut_b (.clk(clk), .rst(rst), .bus(ib));
  fifo_wr_arbiter #(.NUM_REQ(3), .WIDTH(8), .BURST_LEN(1)) dut_c (.clk(clk), .rst(rst), .bus(ic));

  int tests = 0;
  int fails = 0;
  logic [7:0] qa[$];
  logic [7:0] qb[$];
  logic [7:0] qc[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic pos();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && ia.fifo_winc && !ia.fifo_wfull) begin
      chk("a_pending", 32'(qa.size() != 0), 1);
      if (qa.size() != 0) chk("a_word", 32'(ia.fifo_wdata), 32'(qa.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (!rst && ib.fifo_winc && !ib.fifo_wfull) begin
      chk("b_pending", 32'(qb.size() != 0), 1);
      if (qb.size() != 0) chk("b_word", 32'(ib.fifo_wdata), 32'(qb.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (!rst && ic.fifo_winc && !ic.fifo_wfull) begin
      chk("c_pending", 32'(qc.size() != 0), 1);
      if (qc.size() != 0) chk("c_word", 32'(ic.fifo_wdata), 32'(qc.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb[4];
    int nc;
    logic [3:0] ab;
    logic [2:0] ac;
    logic [3:0] exp_ack;

    rst = 1'b1;
    ia.req = '0; ia.req_data = '0; ia.fifo_wfull = 1'b0;
    ib.req = '0; ib.req_data = '0; ib.fifo_wfull = 1'b0;
    ic.req = '0; ic.req_data = '0; ic.fifo_wfull = 1'b0;
    #3;
    chk("rst_a_winc", 32'(ia.fifo_winc), 0);
    chk("rst_a_wdata", 32'(ia.fifo_wdata), 0);
    chk("rst_a_gid", 32'(ia.grant_id), 0);
    chk("rst_a_ack", 32'(ia.ack), 0);
    chk("rst_b_winc", 32'(ib.fifo_winc), 0);
    chk("rst_c_winc", 32'(ic.fifo_winc), 0);
    pos(); pos();
    rst = 1'b0;

    // Full stall holding A5
    ia.req = 4'b0010; ia.req_data[15:8] = 8'hA5;
    neg(); chk("stall_first_ack", 32'(ia.ack), 32'b0010);
    qa.push_back(8'hA5); qa.push_back(8'h5A);
    pos(); ia.req_data[15:8] = 8'h5A; ia.fifo_wfull = 1'b1;
    for (int i = 0; i < 5; i++) begin
      neg();
      chk("stall_winc", 32'(ia.fifo_winc), 1);
      chk("stall_wdata", 32'(ia.fifo_wdata), 32'hA5);
      chk("stall_ack", 32'(ia.ack), 0);
      pos();
    end
    ia.fifo_wfull = 1'b0;
    neg(); chk("stall_resume_ack", 32'(ia.ack), 32'b0010);
    chk("stall_gid", 32'(ia.grant_id), 1);
    pos(); ia.req = '0;
    neg(); chk("stall_release", 32'(ia.ack), 0);
    pos();
    neg(); chk("stall_drained", 32'(ia.fifo_winc), 0);
    pos();

    // Early release of owner 2, then wrap 3 -> 0
    ia.req = 4'b1100; ia.req_data[23:16] = 8'h20; ia.req_data[31:24] = 8'h30;
    neg(); chk("er_ack2", 32'(ia.ack), 32'b0100); qa.push_back(8'h20);
    pos(); ia.req[2] = 1'b0;
    neg(); chk("er_bubble", 32'(ia.ack), 0);
    pos();
    neg(); chk("er_ack3", 32'(ia.ack), 32'b1000); qa.push_back(8'h30);
    pos(); chk("er_gid3", 32'(ia.grant_id), 3); ia.req[3] = 1'b0;
    neg(); chk("er_rel3", 32'(ia.ack), 0);
    pos();
    ia.req = 4'b0100; ia.req_data[23:16] = 8'h21;
    neg(); chk("er_ack2b", 32'(ia.ack), 32'b0100); qa.push_back(8'h21);
    pos(); ia.req = 4'b0011; ia.req_data[7:0] = 8'h01; ia.req_data[15:8] = 8'h11;
    neg(); chk("er_rel2b", 32'(ia.ack), 0);
    pos();
    neg(); chk("er_wrap0", 32'(ia.ack), 32'b0001); qa.push_back(8'h01);
    pos(); ia.req = '0;
    neg(); chk("er_rel0", 32'(ia.ack), 0);
    pos();

    // Requester 0 arriving while owner 3 is mid-burst
    ia.req = 4'b1000; ia.req_data[31:24] = 8'h3A;
    neg(); chk("p_ack3", 32'(ia.ack), 32'b1000); qa.push_back(8'h3A);
    pos(); ia.req_data[31:24] = 8'h3B; ia.req[0] = 1'b1; ia.req_data[7:0] = 8'h0F;
`ifdef FIFO_WR_ARB_PRIO0_EN
    neg(); chk("p_trunc", 32'(ia.ack), 0);
    pos();
    neg(); chk("p_grant0", 32'(ia.ack), 32'b0001); qa.push_back(8'h0F);
    pos(); chk("p_gid0", 32'(ia.grant_id), 0); ia.req[0] = 1'b0;
    neg(); chk("p_rel0", 32'(ia.ack), 0);
    pos();
    neg(); chk("p_resume3", 32'(ia.ack), 32'b1000); qa.push_back(8'h3B);
    pos(); ia.req[3] = 1'b0;
`else
    neg(); chk("np_keep3", 32'(ia.ack), 32'b1000); qa.push_back(8'h3B);
    pos(); ia.req[3] = 1'b0;
    neg(); chk("np_rel3", 32'(ia.ack), 0);
    pos();
    neg(); chk("np_grant0", 32'(ia.ack), 32'b0001); qa.push_back(8'h0F);
    pos(); chk("np_gid0", 32'(ia.grant_id), 0); ia.req[0] = 1'b0;
`endif
    neg(); chk("p_final_rel", 32'(ia.ack), 0);
    pos();
    neg(); pos();

    // Reset mid-burst with a word sitting in the output stage
    ia.req = 4'b0010; ia.req_data[15:8] = 8'h77;
    neg(); chk("rst_mid_ack", 32'(ia.ack), 32'b0010); qa.push_back(8'h77);
    pos(); chk("rst_mid_winc_pre", 32'(ia.fifo_winc), 1);
    rst = 1'b1;
    #1;
    chk("rst_mid_winc", 32'(ia.fifo_winc), 0);
    chk("rst_mid_gid", 32'(ia.grant_id), 0);
    chk("rst_mid_ack0", 32'(ia.ack), 0);
    qa.delete();
    ia.req = 4'b0110; ia.req_data[23:16] = 8'h22;
    pos(); rst = 1'b0;
    neg(); chk("rst_first_grant", 32'(ia.ack), 32'b0010); qa.push_back(8'h77);
    pos(); ia.req = '0;
    neg(); chk("rst_first_rel", 32'(ia.ack), 0);
    pos();
    neg(); pos();

    // Round robin, BURST_LEN=2, all requesting
    for (int i = 0; i < 4; i++) begin
      nb[i] = 0;
      ib.req_data[i*8 +: 8] = 8'(16 * i);
    end
    for (int r = 0; r < 4; r++)
      for (int i = 0; i < 4; i++)
        for (int w = 0; w < 2; w++)
          qb.push_back(8'(16 * i + 2 * r + w));
    ib.req = 4'b1111;
    for (int k = 0; k < 48; k++) begin
      neg();
      exp_ack = (k % 3 != 2) ? 4'(1 << ((k / 3) % 4)) : 4'b0000;
      chk("rr_ack", 32'(ib.ack), 32'(exp_ack));
      if (k > 0) chk("rr_winc", 32'(ib.fifo_winc), 32'((k - 1) % 3 != 2));
      ab = ib.ack;
      pos();
      for (int i = 0; i < 4; i++) begin
        if (ab[i]) begin
          nb[i]++;
          ib.req_data[i*8 +: 8] = 8'(16 * i + nb[i]);
        end
      end
    end
    ib.req = '0;
    neg(); pos();

    // Single requester, BURST_LEN=1, NUM_REQ=3
    nc = 0;
    ic.req = 3'b010; ic.req_data[15:8] = 8'h00;
    for (int k = 0; k < 200; k++) begin
      neg();
      if (k % 2 == 0) begin
        chk("single_ack", 32'(ic.ack), 32'b010);
        qc.push_back(8'(nc));
      end else begin
        chk("single_bubble", 32'(ic.ack), 0);
      end
      if (k > 0) begin
        chk("single_winc", 32'(ic.fifo_winc), 32'(k % 2 == 1));
        chk("single_gid", 32'(ic.grant_id), 1);
      end
      ac = ic.ack;
      pos();
      if (ac[1]) begin
        nc++;
        ic.req_data[15:8] = 8'(nc);
      end
    end
    chk("single_count", 32'(nc), 100);
    ic.req = 3'b100; ic.req_data[23:16] = 8'hC2;
    neg(); chk("c_ack2", 32'(ic.ack), 32'b100); qc.push_back(8'hC2);
    pos(); ic.req = 3'b011; ic.req_data[7:0] = 8'hC0;
    neg(); chk("c_rel2", 32'(ic.ack), 0);
    pos();
    neg(); chk("c_wrap0", 32'(ic.ack), 32'b001); qc.push_back(8'hC0);
    pos(); ic.req = '0;
    neg(); pos();
    neg(); pos();

    chk("a_drain", 32'(qa.size()), 0);
    chk("b_drain", 32'(qb.size()), 0);
    chk("c_drain", 32'(qc.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
